// File: rtl/uart_text_pkg.sv
// Shared definitions for the UART-to-character-RAM writer: ASCII codes,
// FSM state encoding and a printable-glyph test.
package uart_text_pkg;

    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_FF    = 8'h0C;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_TILDE = 8'h7E;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WRITE,
        HOLD,
        CLEAR
    } state_t;

    // True for bytes that have a visible glyph (space through tilde).
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASC_SPACE) && (b <= ASC_TILDE);
    endfunction

endpackage

// File: rtl/uart_text_writer_sync_rise.sv
// Two-flop synchronizer for a W-bit data bus and a 1-bit control level,
// with a one-cycle pulse on each rising edge of the synchronized control.
module sync_rise #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_in,
    input  logic         ctrl_in,
    output logic [W-1:0] data_sync,
    output logic         rise
);

    logic [W-1:0] data_s1;
    logic [W-1:0] data_s2;
    logic         ctrl_s1;
    logic         ctrl_s2;
    logic         ctrl_s3;

    // Double-register both inputs; a third control flop remembers the old level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_s1 <= '0;
            data_s2 <= '0;
            ctrl_s1 <= 1'b0;
            ctrl_s2 <= 1'b0;
            ctrl_s3 <= 1'b0;
        end else begin
            data_s1 <= data_in;
            data_s2 <= data_s1;
            ctrl_s1 <= ctrl_in;
            ctrl_s2 <= ctrl_s1;
            ctrl_s3 <= ctrl_s2;
        end
    end

    assign data_sync = data_s2;
    assign rise      = ctrl_s2 & ~ctrl_s3;

endmodule

// File: rtl/uart_text_writer.sv
// Writes received UART bytes into the VGA character RAM at a tracked cursor.
// Build option UART_TEXT_CTRL_EN: when defined, CR/LF/BS/FF are interpreted
// and other non-printable bytes are dropped; when undefined every byte is
// written as a glyph and the clear/backspace logic is not built.
// Handshake: data_ready is a level; each rising edge (after synchronization)
// offers one byte. A byte offered while busy is dropped and sets overrun.
module uart_text_writer
    import uart_text_pkg::*;
#(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 40,
    parameter int          ADDR_W    = 12,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic                     clock100,
    input  logic                     reset,
    input  logic [7:0]               data_in,
    input  logic                     data_ready,
    output logic [7:0]               data_out,
    output logic [ADDR_W-1:0]        wraddress,
    output logic                     wren,
    output logic                     busy,
    output logic                     overrun,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic [$clog2(ROWS)-1:0]  cursor_row
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int CELLS = COLS * ROWS;

    state_t            state;
    state_t            state_d;
    logic [7:0]        byte_q;
    logic [7:0]        byte_d;
    logic [7:0]        data_out_d;
    logic [ADDR_W-1:0] wraddress_d;
    logic              wren_d;
    logic              overrun_d;
    logic [CW-1:0]     col_d;
    logic [RW-1:0]     row_d;
    logic [CW-1:0]     adv_col;
    logic [RW-1:0]     adv_row;
    logic [RW-1:0]     lf_row;
    logic [7:0]        data_sync;
    logic              new_byte;
`ifdef UART_TEXT_CTRL_EN
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_d;
    logic [CW-1:0]     bs_col;
`endif

    sync_rise #(.W(8)) u_sync (
        .clk       (clock100),
        .rst       (reset),
        .data_in   (data_in),
        .ctrl_in   (data_ready),
        .data_sync (data_sync),
        .rise      (new_byte)
    );

    // Linear RAM address of a cell; the product is formed at full ADDR_W width.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [CW-1:0] c,
                                                    input logic [RW-1:0] r);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    assign busy = (state != IDLE);

    // Cursor after one glyph (wrap to next row, then to top) and after a line feed.
    always_comb begin
        adv_col = cursor_col + CW'(1);
        adv_row = cursor_row;
        lf_row  = (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + RW'(1);
        if (cursor_col == CW'(COLS - 1)) begin
            adv_col = '0;
            adv_row = lf_row;
        end
    end

`ifdef UART_TEXT_CTRL_EN
    assign bs_col = cursor_col - CW'(1);
`endif

    // Next-state and next-output logic for the write FSM.
    always_comb begin
        state_d     = state;
        byte_d      = byte_q;
        data_out_d  = data_out;
        wraddress_d = wraddress;
        wren_d      = wren;
        col_d       = cursor_col;
        row_d       = cursor_row;
        overrun_d   = overrun | (new_byte && (state != IDLE));
`ifdef UART_TEXT_CTRL_EN
        clr_cnt_d   = clr_cnt;
`endif
        case (state)
            IDLE: begin
                wren_d = 1'b0;
                if (new_byte) begin
                    byte_d  = data_sync;
                    state_d = DECODE;
                end
            end
            DECODE: begin
`ifdef UART_TEXT_CTRL_EN
                state_d = IDLE;
                if (is_printable(byte_q)) begin
                    data_out_d  = byte_q;
                    wraddress_d = cell_addr(cursor_col, cursor_row);
                    col_d       = adv_col;
                    row_d       = adv_row;
                    state_d     = WRITE;
                end else begin
                    case (byte_q)
                        ASC_CR: col_d = '0;
                        ASC_LF: row_d = lf_row;
                        ASC_BS: begin
                            if (cursor_col != '0) begin
                                col_d       = bs_col;
                                data_out_d  = FILL_CHAR;
                                wraddress_d = cell_addr(bs_col, cursor_row);
                                state_d     = WRITE;
                            end
                        end
                        ASC_FF: begin
                            data_out_d  = FILL_CHAR;
                            wraddress_d = '0;
                            clr_cnt_d   = '0;
                            state_d     = CLEAR;
                        end
                        default: state_d = IDLE;
                    endcase
                end
`else
                data_out_d  = byte_q;
                wraddress_d = cell_addr(cursor_col, cursor_row);
                col_d       = adv_col;
                row_d       = adv_row;
                state_d     = WRITE;
`endif
            end
            WRITE: begin
                wren_d  = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                wren_d  = 1'b1;
                state_d = IDLE;
            end
`ifdef UART_TEXT_CTRL_EN
            CLEAR: begin
                wren_d      = 1'b1;
                wraddress_d = clr_cnt;
                if (clr_cnt == ADDR_W'(CELLS - 1)) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt + ADDR_W'(1);
                end
            end
`endif
            default: begin
                wren_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clock100 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_q     <= '0;
            data_out   <= '0;
            wraddress  <= '0;
            wren       <= 1'b0;
            overrun    <= 1'b0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            state      <= state_d;
            byte_q     <= byte_d;
            data_out   <= data_out_d;
            wraddress  <= wraddress_d;
            wren       <= wren_d;
            overrun    <= overrun_d;
            cursor_col <= col_d;
            cursor_row <= row_d;
        end
    end

`ifdef UART_TEXT_CTRL_EN
    // Clear-screen address counter.
    always_ff @(posedge clock100 or posedge reset) begin
        if (reset) begin
            clr_cnt <= '0;
        end else begin
            clr_cnt <= clr_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_text_writer.sv
// Directed bench for uart_text_writer (80x40 grid, 12-bit addresses).
module tb_uart_text_writer;

    logic        clock100 = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        data_ready;
    logic [7:0]  data_out;
    logic [11:0] wraddress;
    logic        wren;
    logic        busy;
    logic        overrun;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected write stream: one {addr, data} entry per wren-high cycle.
    logic [19:0] exp_q[$];

    uart_text_writer #(
        .COLS(80), .ROWS(40), .ADDR_W(12), .FILL_CHAR(8'h20)
    ) dut (
        .clock100   (clock100),
        .reset      (reset),
        .data_in    (data_in),
        .data_ready (data_ready),
        .data_out   (data_out),
        .wraddress  (wraddress),
        .wren       (wren),
        .busy       (busy),
        .overrun    (overrun),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    // clock / reset
    always #5 clock100 = ~clock100;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // scoreboard: every wren-high cycle must match the head of exp_q
    always @(negedge clock100) begin
        logic [19:0] e;
        if (!reset && wren) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wren), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("write", 32'({wraddress, data_out}), 32'(e));
            end
        end
    end

    // driver tasks
    task automatic expect_write(input logic [11:0] addr, input logic [7:0] d);
        exp_q.push_back({addr, d});
        exp_q.push_back({addr, d});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clock100);
            n++;
        end
        check("busy_timeout", 32'(busy), 32'd0);
        repeat (2) @(negedge clock100);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock100);
        data_in    = b;
        data_ready = 1'b1;
        @(negedge clock100);
        data_ready = 1'b0;
        @(negedge clock100);
        check("busy_before_capture", 32'(busy), 32'd0);
        @(negedge clock100);
        check("busy_after_capture", 32'(busy), 32'd1);
        wait_idle();
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, 32'(cursor_col), 32'(col));
        check({tag, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    task automatic check_pending(input string tag);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock100);
        reset = 1'b1;
        repeat (2) @(negedge clock100);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int i;
        reset      = 1'b1;
        data_in    = 8'h00;
        data_ready = 1'b0;
        repeat (3) @(negedge clock100);
        reset = 1'b0;
        @(negedge clock100);

        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_wraddress", 32'(wraddress), 32'd0);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check_cursor("rst", 0, 0);

        // 'A' then 'B'
        expect_write(12'd0, 8'h41);
        send_byte(8'h41);
        expect_write(12'd1, 8'h42);
        send_byte(8'h42);
        check_pending("ab");
        check_cursor("ab", 2, 0);

        // second byte offered while the first is still being written
        expect_write(12'd2, 8'h61);
        @(negedge clock100);
        data_in = 8'h61; data_ready = 1'b1;
        @(negedge clock100);
        data_ready = 1'b0;
        @(negedge clock100);
        data_in = 8'h62; data_ready = 1'b1;
        @(negedge clock100);
        data_ready = 1'b0;
        repeat (2) @(negedge clock100);
        wait_idle();
        check_pending("overrun");
        check("overrun_set", 32'(overrun), 32'd1);
        check_cursor("overrun", 3, 0);

        // reset during HOLD
        exp_q.push_back({12'd3, 8'h72});
        @(negedge clock100);
        data_in = 8'h72; data_ready = 1'b1;
        @(negedge clock100);
        data_ready = 1'b0;
        n = 0;
        while (!wren && n < 20) begin
            @(negedge clock100);
            n++;
        end
        check("hold_wren_seen", 32'(wren), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_data_out", 32'(data_out), 32'd0);
        check("arst_wraddress", 32'(wraddress), 32'd0);
        check("arst_wren", 32'(wren), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check_cursor("arst", 0, 0);
        @(negedge clock100);
        reset = 1'b0;
        check_pending("arst");
        expect_write(12'd0, 8'h43);
        send_byte(8'h43);
        check_pending("after_arst");
        check_cursor("after_arst", 1, 0);

        // row wrap, then fill to the last cell and wrap the whole screen
        do_reset();
        for (int k = 0; k < 80; k++) begin
            expect_write(12'(k), 8'h78);
            send_byte(8'h78);
        end
        expect_write(12'd80, 8'h79);
        send_byte(8'h79);
        check_pending("row_wrap");
        check_cursor("row_wrap", 1, 1);
        for (int k = 81; k < 3199; k++) begin
            expect_write(12'(k), 8'(8'h30 + (k % 10)));
            send_byte(8'(8'h30 + (k % 10)));
        end
        check_pending("fill");
        check_cursor("last_cell", 79, 39);
        expect_write(12'd3199, 8'h7A);
        send_byte(8'h7A);
        check_pending("screen_wrap");
        check_cursor("screen_wrap", 0, 0);

`ifdef UART_TEXT_CTRL_EN
        do_reset();
        send_byte(8'h0A);
        send_byte(8'h0A);
        check_cursor("lf", 0, 2);
        for (int k = 0; k < 5; k++) begin
            expect_write(12'(160 + k), 8'h6B);
            send_byte(8'h6B);
        end
        check_cursor("pre_bs", 5, 2);
        expect_write(12'd164, 8'h20);
        send_byte(8'h08);
        check_pending("bs");
        check_cursor("bs", 4, 2);
        send_byte(8'h0D);
        check_cursor("cr", 0, 2);
        send_byte(8'h08);
        check_cursor("bs_col0", 0, 2);
        send_byte(8'h01);
        send_byte(8'h7F);
        check_cursor("discard", 0, 2);
        check_pending("ctrl");

        // form feed with a byte offered mid-clear
        for (int k = 0; k < 3200; k++) exp_q.push_back({12'(k), 8'h20});
        @(negedge clock100);
        data_in = 8'h0C; data_ready = 1'b1;
        @(negedge clock100);
        data_ready = 1'b0;
        n = 0;
        i = 0;
        while (i < 5000) begin
            @(negedge clock100);
            i++;
            if (busy) n++;
            else if (n > 0) break;
            if (n == 20) begin
                data_in = 8'h51; data_ready = 1'b1;
            end else if (n == 21) begin
                data_ready = 1'b0;
            end
        end
        check("clear_busy_cycles", 32'(n), 32'd3201);
        repeat (3) @(negedge clock100);
        check_pending("clear");
        check("clear_overrun", 32'(overrun), 32'd1);
        check_cursor("clear", 0, 0);
`else
        // control codes are ordinary glyphs in this build
        do_reset();
        expect_write(12'd0, 8'h0D);
        send_byte(8'h0D);
        expect_write(12'd1, 8'h7F);
        send_byte(8'h7F);
        expect_write(12'd2, 8'h0C);
        send_byte(8'h0C);
        expect_write(12'd3, 8'h08);
        send_byte(8'h08);
        expect_write(12'd4, 8'h00);
        send_byte(8'h00);
        check_pending("glyph_ctrl");
        check_cursor("glyph_ctrl", 5, 0);
        check("glyph_overrun", 32'(overrun), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_text_writer.md
# uart_text_writer

Parametrised successor to the UART-to-text-memory interface. It takes bytes from the UART receiver and writes them into the VGA character RAM at a tracked cursor position. Grid size is configurable. Control characters are interpreted, a full-screen clear is supported, and busy, overrun and cursor status are exported for the VGA cursor renderer.

## Interface
Parameters:
- COLS, 80, characters per row (≥2)
- ROWS, 40, rows on screen (≥2)
- ADDR_W, 12, character RAM address width; must satisfy COLS*ROWS ≤ 2**ADDR_W
- FILL_CHAR, 8'h20, byte written by clear-screen and backspace

Ports:
- clock100  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- data_in  in  8  received UART byte; stable while data_ready is high
- data_ready  in  1  byte-valid level from the UART; asynchronous to this block
- data_out  out  8  character-RAM write data
- wraddress  out  ADDR_W  character-RAM write address, computed as row*COLS + col
- wren  out  1  character-RAM write enable
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky flag; set when a byte arrives while busy
- cursor_col  out  $clog2(COLS)  current cursor column
- cursor_row  out  $clog2(ROWS)  current cursor row

## Operation
- **Synchronizer:** data_in and data_ready each pass through 2 flops. A third flop on data_ready gives rise detection: new = s2 & ~s3. Only rising edges count; a level held high is taken once.
- **States:** IDLE, DECODE, WRITE, HOLD, CLEAR.
- **IDLE:** wren ← 0. On new, capture data_s2 → DECODE.
- **DECODE:**
  - Printable byte (0x20–0x7E), or any byte when control decode is compiled out: data_out ← byte, wraddress ← current cursor, advance cursor → WRITE.
  - CR 0x0D: col ← 0 → IDLE.
  - LF 0x0A: row ← row+1, wrapping ROWS-1 → 0 → IDLE.
  - BS 0x08:
    - col > 0: col ← col-1, data_out ← FILL_CHAR, wraddress ← new cursor → WRITE.
    - col = 0: no-op → IDLE.
  - FF 0x0C: wraddress ← 0, data_out ← FILL_CHAR → CLEAR.
  - Any other byte: discarded → IDLE.
- **WRITE:** wren ← 1 → HOLD.
- **HOLD:** wren stays 1 → IDLE. wren is therefore high for exactly 2 cycles, and data_out/wraddress are stable for the whole pulse.
- **CLEAR:** wren ← 1 and wraddress increments every cycle from 0 to COLS*ROWS-1. After the last address: wren ← 0, cursor ← (0,0) → IDLE.
- **Cursor advance:** col+1. At COLS-1, col ← 0 and row+1. At the last row, row ← 0; there is no scrolling.
- **Arithmetic:** all address arithmetic is done in ADDR_W bits. The product row*COLS must not truncate.
- **Overrun:** new while state ≠ IDLE sets overrun; the byte is dropped. Only reset clears overrun.
- **Reset:** forces state IDLE immediately, including mid-write or mid-clear. Every output resets to 0: data_out, wraddress, wren, busy, overrun, cursor_col, cursor_row. Synchronizer flops also reset to 0, so a data_ready already high when reset releases produces one new.

## Timing
- Let E1 be the first clock100 edge that samples data_ready = 1.
- E3: byte captured, busy = 1.
- E4: data_out/wraddress valid, cursor updated.
- E5–E7: wren = 1 for 2 cycles.
- E6: busy = 0.
- Printable-byte throughput: 4 cycles per byte, plus the 2-cycle synchronizer latency.
- CR/LF/discarded bytes: busy for 1 cycle only.
- Clear: busy for COLS*ROWS+1 cycles. For 80×40, that is 3201 cycles (32.01 µs).
- A new arriving in the same cycle the FSM returns to IDLE is accepted, not an overrun.

## Configuration
- `UART_TEXT_CTRL_EN` defined: CR, LF, BS and FF are decoded as above; other bytes below 0x20, and 0x7F, are discarded.
- Not defined: every byte, including 0x00–0x1F and 0x7F, is written as a printable glyph with normal cursor advance. The CLEAR state and the BS path are not synthesised.

## Structure
- Package uart_text_pkg holds:
  - ASCII constants: ASC_CR, ASC_LF, ASC_BS, ASC_FF, ASC_SPACE
  - typedef enum state_t {IDLE, DECODE, WRITE, HOLD, CLEAR}
- Sub-module sync_rise:
  - parameter W
  - 2-flop synchronizer for a W-bit bus, plus a rise pulse on bit 0 of the control input
  - asynchronous reset

## Test plan
- Reset, then bytes 'A' and 'B' with COLS=80 → writes (addr 0, 0x41) then (addr 1, 0x42); each wren pulse is exactly 2 cycles; cursor ends at (col 2, row 0).
- 80 × 'x' then 'y' → 'y' written at address 80; cursor at (1,1).
- Cursor at (79,39), then 'z' → write at address 3199; cursor wraps to (0,0).
- Cursor at (5,2), then BS → write FILL_CHAR at address 164, cursor at (4,2). Then CR → cursor at (0,2) with no wren. Then BS → no write.
- FF → 3200 consecutive wren cycles, addresses 0..3199, data 0x20; cursor (0,0). A second byte sent mid-clear sets overrun = 1 and produces no extra write.
- Assert reset for 1 cycle during HOLD → wren = 0 and all outputs 0 asynchronously; the next byte writes to address 0.
